// File: rtl/scoreboard_pkg.sv
// Shared types, default constants and saturating score arithmetic
// for the scoreboard game-control stage.
package scoreboard_pkg;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    PAUSE,
    EXPIRED
  } state_t;

  localparam int SHOT_INIT_DEF = 24;
  localparam int SCORE_MAX_DEF = 99;
  localparam int SCORE_W       = 8;
  localparam int SHOT_W        = 6;

  // The sum is one bit wider than the score, so it cannot wrap before the clamp.
  function automatic logic [SCORE_W-1:0] sat_add(input logic [SCORE_W-1:0] score,
                                                 input logic [1:0]         n,
                                                 input logic [SCORE_W-1:0] max);
    logic [SCORE_W:0] sum;
    sum = {1'b0, score} + {{(SCORE_W-1){1'b0}}, n};
    if (sum > {1'b0, max}) begin
      return max;
    end
    return sum[SCORE_W-1:0];
  endfunction

endpackage

// File: rtl/btn_debounce.sv
// Push-button conditioner: 2-flop synchronizer, debounce counter on the
// accepted level, and a single-cycle pulse on its rising edge.
module btn_debounce #(
  parameter int DEB_CYCLES = 20
) (
  input  logic clk_scan,
  input  logic rst,
  input  logic i_btn,
  output logic o_pulse
);

  localparam int CNT_W = $clog2(DEB_CYCLES + 1);

  logic             r_sync1;
  logic             r_sync2;
  logic             r_level;
  logic             r_level_d;
  logic [CNT_W-1:0] r_cnt;

  always_ff @(posedge clk_scan or posedge rst) begin
    if (rst) begin
      r_sync1   <= 1'b0;
      r_sync2   <= 1'b0;
      r_level   <= 1'b0;
      r_level_d <= 1'b0;
      r_cnt     <= '0;
    end else begin
      r_sync1   <= i_btn;
      r_sync2   <= r_sync1;
      r_level_d <= r_level;
      // Counts consecutive samples that disagree with the accepted level.
      if (r_sync2 == r_level) begin
        r_cnt <= '0;
      end else if (r_cnt == CNT_W'(DEB_CYCLES - 1)) begin
        r_level <= r_sync2;
        r_cnt   <= '0;
      end else begin
        r_cnt <= r_cnt + CNT_W'(1);
      end
    end
  end

  assign o_pulse = r_level & ~r_level_d;

endmodule

// File: rtl/scoreboard_ctrl.sv
// Basketball scoreboard game control: run/pause FSM, shot clock, two
// saturating score accumulators and the expiry buzzer.
module scoreboard_ctrl
  import scoreboard_pkg::*;
#(
  parameter int TICKS_PER_SEC = 1000,
  parameter int SHOT_INIT     = SHOT_INIT_DEF,
  parameter int SCORE_MAX     = SCORE_MAX_DEF,
  parameter int DEB_CYCLES    = 20,
  parameter int BUZZ_CYCLES   = 500
) (
  input  logic               clk_scan,
  input  logic               rst,
  input  logic               btn_a1,
  input  logic               btn_a2,
  input  logic               btn_a3,
  input  logic               btn_b1,
  input  logic               btn_b2,
  input  logic               btn_b3,
  input  logic               btn_start,
  input  logic               btn_shot_rst,
  output logic [SCORE_W-1:0] score_a,
  output logic [SCORE_W-1:0] score_b,
  output logic [SHOT_W-1:0]  shot_clock,
  output logic               running,
  output logic               buzzer
);

  localparam int MS_W = (TICKS_PER_SEC > 1) ? $clog2(TICKS_PER_SEC) : 1;
  localparam int BZ_W = $clog2(BUZZ_CYCLES + 1);

  logic [7:0] w_btn;
  logic [7:0] w_pulse;
  logic       w_start;
  logic       w_srst;
  logic       w_tick;
  logic       w_expire;
  logic [1:0] w_add_a;
  logic [1:0] w_add_b;
  state_t     w_state_next;

  state_t             r_state;
  logic [MS_W-1:0]    r_ms_cnt;
  logic [SHOT_W-1:0]  r_shot;
  logic [SCORE_W-1:0] r_score_a;
  logic [SCORE_W-1:0] r_score_b;
  logic               r_running;
  logic               r_buzzer;
  logic [BZ_W-1:0]    r_buzz_cnt;

  assign w_btn = {btn_shot_rst, btn_start, btn_b3, btn_b2, btn_b1, btn_a3, btn_a2, btn_a1};

  for (genvar g = 0; g < 8; g++) begin : g_deb
    btn_debounce #(
      .DEB_CYCLES(DEB_CYCLES)
    ) u_deb (
      .clk_scan(clk_scan),
      .rst     (rst),
      .i_btn   (w_btn[g]),
      .o_pulse (w_pulse[g])
    );
  end

  assign w_start  = w_pulse[6];
  assign w_srst   = w_pulse[7];
  assign w_tick   = (r_state == RUN) && (r_ms_cnt == MS_W'(TICKS_PER_SEC - 1));
  // A reload arriving with the final decrement cancels the expiry.
  assign w_expire = w_tick && (r_shot == SHOT_W'(1)) && !w_srst;

  always_comb begin
    w_add_a = 2'd0;
    w_add_b = 2'd0;
    if (w_pulse[2])      w_add_a = 2'd3;
    else if (w_pulse[1]) w_add_a = 2'd2;
    else if (w_pulse[0]) w_add_a = 2'd1;
    if (w_pulse[5])      w_add_b = 2'd3;
    else if (w_pulse[4]) w_add_b = 2'd2;
    else if (w_pulse[3]) w_add_b = 2'd1;
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      IDLE:    if (w_start) w_state_next = RUN;
      RUN: begin
        if (w_expire)     w_state_next = EXPIRED;
        else if (w_start) w_state_next = PAUSE;
      end
      PAUSE:   if (w_start) w_state_next = RUN;
      EXPIRED: if (w_srst)  w_state_next = IDLE;
      default: w_state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk_scan or posedge rst) begin
    if (rst) begin
      r_state   <= IDLE;
      r_running <= 1'b0;
    end else begin
      r_state   <= w_state_next;
      r_running <= (w_state_next == RUN);
    end
  end

  always_ff @(posedge clk_scan or posedge rst) begin
    if (rst) begin
      r_ms_cnt <= '0;
      r_shot   <= SHOT_W'(SHOT_INIT);
    end else begin
      if (w_srst || w_expire) begin
        r_ms_cnt <= '0;
      end else if (r_state == RUN) begin
        r_ms_cnt <= w_tick ? '0 : r_ms_cnt + MS_W'(1);
      end
      if (w_srst) begin
        r_shot <= SHOT_W'(SHOT_INIT);
      end else if (w_tick) begin
        r_shot <= r_shot - SHOT_W'(1);
      end
    end
  end

  always_ff @(posedge clk_scan or posedge rst) begin
    if (rst) begin
      r_score_a <= '0;
      r_score_b <= '0;
    end else begin
      r_score_a <= sat_add(r_score_a, w_add_a, SCORE_W'(SCORE_MAX));
      r_score_b <= sat_add(r_score_b, w_add_b, SCORE_W'(SCORE_MAX));
    end
  end

  // The count holds the cycles remaining after the current one.
  always_ff @(posedge clk_scan or posedge rst) begin
    if (rst) begin
      r_buzzer   <= 1'b0;
      r_buzz_cnt <= '0;
    end else if (w_expire) begin
      r_buzzer   <= 1'b1;
      r_buzz_cnt <= BZ_W'(BUZZ_CYCLES - 1);
    end else if (w_srst) begin
      r_buzzer   <= 1'b0;
      r_buzz_cnt <= '0;
    end else if (r_buzzer) begin
      if (r_buzz_cnt == '0) begin
        r_buzzer <= 1'b0;
      end else begin
        r_buzz_cnt <= r_buzz_cnt - BZ_W'(1);
      end
    end
  end

  assign score_a    = r_score_a;
  assign score_b    = r_score_b;
  assign shot_clock = r_shot;
  assign running    = r_running;
  assign buzzer     = r_buzzer;

endmodule
